// File: rtl/decode_alu_branch.sv
// katp91 execute helper: instruction latch and decoder, 16/8-bit ALU, status flags, branch test.
// Defining ALU_MUL_EN turns dual-operand op 9 into an unsigned multiply (low half of product).
module decode_alu_branch #(
  parameter logic [15:0] RESET_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] word_in,
  input  logic        word_load,
  input  logic [15:0] value1,
  input  logic [15:0] value2,
  input  logic        flags_we,
  input  logic        int_en_clr,
  input  logic        int_en_set,
  output logic [3:0]  operator_group,
  output logic [3:0]  operator,
  output logic [2:0]  rg1,
  output logic [2:0]  rg2,
  output logic [7:0]  val,
  output logic [7:0]  decoder_flags,
  output logic [9:0]  relative_addr,
  output logic [15:0] alu_out,
  output logic [3:0]  alu_flags,
  output logic [7:0]  flags,
  output logic        is_checked
);

  localparam logic [3:0] G_RJMP    = 4'd0;
  localparam logic [3:0] G_CRVMATH = 4'd1;
  localparam logic [3:0] G_SFLAG   = 4'd2;
  localparam logic [3:0] G_UFLAG   = 4'd3;
  localparam logic [3:0] G_SPECIAL = 4'd4;
  localparam logic [3:0] G_INVALID = 4'd5;
  localparam logic [3:0] G_WRRMATH = 4'd8;
  localparam logic [3:0] G_WRSMATH = 4'd9;
  localparam logic [3:0] G_CRRMATH = 4'd10;
  localparam logic [3:0] G_CRSMATH = 4'd11;

  logic [15:0] word_q;
  logic [7:0]  flags_reg;
  logic [7:0]  flags_next;

  logic        byte_mode;
  logic        single_op;
  logic        pass_a;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] res;
  logic [15:0] res_m;
  logic [16:0] wide;
  logic        c_in;
  logic        c_f;
  logic        v_f;
`ifdef ALU_MUL_EN
  logic [31:0] prod;
`endif

  // Sign bit and carry/borrow position depend on the operating width.
  function automatic logic msb_of(input logic [15:0] x, input logic bm);
    return bm ? x[7] : x[15];
  endfunction

  function automatic logic carry_of(input logic [16:0] x, input logic bm);
    return bm ? x[8] : x[16];
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= RESET_WORD;
    end else if (word_load) begin
      word_q <= word_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_reg <= 8'h00;
    end else begin
      flags_reg <= flags_next;
    end
  end

  always_comb begin
    operator_group = G_RJMP;
    operator       = 4'd0;
    rg1            = 3'd0;
    rg2            = 3'd0;
    val            = 8'h00;
    decoder_flags  = 8'h00;
    relative_addr  = 10'd0;
    case (word_q[15:14])
      2'b00: begin
        operator_group = G_RJMP;
        operator       = word_q[13:10];
        relative_addr  = word_q[9:0];
      end
      2'b01: begin
        operator_group = G_CRVMATH;
        operator       = {1'b0, word_q[13:11]};
        rg1            = word_q[10:8];
        val            = word_q[7:0];
      end
      default: begin
        if (word_q[15:12] != 4'hF) begin
          operator_group = word_q[15:12];
          rg1            = word_q[11:9];
          rg2            = word_q[8:6];
          operator       = word_q[3:0];
        end else begin
          case (word_q[11:10])
            2'b00:   operator_group = G_SPECIAL;
            2'b01:   operator_group = G_SFLAG;
            2'b10:   operator_group = G_UFLAG;
            default: operator_group = G_INVALID;
          endcase
          decoder_flags = word_q[7:0];
          operator      = word_q[3:0];
        end
      end
    endcase
  end

  always_comb begin
    byte_mode = operator_group inside {G_CRVMATH, G_CRRMATH, G_CRSMATH};
    single_op = operator_group inside {G_WRSMATH, G_CRSMATH};
    a         = byte_mode ? {8'h00, value1[7:0]} : value1;
    b         = byte_mode ? {8'h00, value2[7:0]} : value2;
    c_in      = flags_reg[3];
    wide      = 17'd0;
    res       = a;
    pass_a    = 1'b0;
    c_f       = flags_reg[3];
    v_f       = flags_reg[2];
`ifdef ALU_MUL_EN
    prod      = 32'd0;
`endif
    if (single_op) begin
      case (operator)
        4'd0: begin
          wide = {1'b0, a} + 17'd1;
          res  = wide[15:0];
          c_f  = carry_of(wide, byte_mode);
          v_f  = !msb_of(a, byte_mode) && msb_of(res, byte_mode);
        end
        4'd1: begin
          wide = {1'b0, a} - 17'd1;
          res  = wide[15:0];
          c_f  = carry_of(wide, byte_mode);
          v_f  = msb_of(a, byte_mode) && !msb_of(res, byte_mode);
        end
        4'd2: begin
          res = ~a;
          v_f = 1'b0;
        end
        4'd3: begin
          wide = 17'd0 - {1'b0, a};
          res  = wide[15:0];
          c_f  = carry_of(wide, byte_mode);
          v_f  = msb_of(a, byte_mode) && msb_of(res, byte_mode);
        end
        4'd4: begin
          res = {a[14:0], 1'b0};
          c_f = msb_of(a, byte_mode);
          v_f = 1'b0;
        end
        4'd5: begin
          res = {1'b0, a[15:1]};
          c_f = a[0];
          v_f = 1'b0;
        end
        4'd6: begin
          res = {a[14:0], c_in};
          c_f = msb_of(a, byte_mode);
          v_f = 1'b0;
        end
        4'd7: begin
          res = byte_mode ? {8'h00, c_in, a[7:1]} : {c_in, a[15:1]};
          c_f = a[0];
          v_f = 1'b0;
        end
        4'd8: begin
          res = byte_mode ? a : {a[7:0], a[15:8]};
          v_f = 1'b0;
        end
        default: ;
      endcase
    end else begin
      case (operator)
        4'd0, 4'd1: begin
          wide = {1'b0, a} + {1'b0, b} + {16'h0000, c_in & (operator == 4'd1)};
          res  = wide[15:0];
          c_f  = carry_of(wide, byte_mode);
          v_f  = (msb_of(a, byte_mode) == msb_of(b, byte_mode)) &&
                 (msb_of(res, byte_mode) != msb_of(a, byte_mode));
        end
        4'd2, 4'd3, 4'd7: begin
          wide   = {1'b0, a} - {1'b0, b} - {16'h0000, c_in & (operator == 4'd3)};
          res    = wide[15:0];
          c_f    = carry_of(wide, byte_mode);
          v_f    = (msb_of(a, byte_mode) != msb_of(b, byte_mode)) &&
                   (msb_of(res, byte_mode) != msb_of(a, byte_mode));
          pass_a = (operator == 4'd7);
        end
        4'd4: begin
          res = a & b;
          v_f = 1'b0;
        end
        4'd5: begin
          res = a | b;
          v_f = 1'b0;
        end
        4'd6: begin
          res = a ^ b;
          v_f = 1'b0;
        end
        4'd8: begin
          res = b;
          v_f = 1'b0;
        end
`ifdef ALU_MUL_EN
        4'd9: begin
          prod = {16'h0000, a} * {16'h0000, b};
          res  = prod[15:0];
          c_f  = byte_mode ? (|prod[15:8]) : (|prod[31:16]);
          v_f  = 1'b0;
        end
`endif
        default: ;
      endcase
    end
    res_m     = byte_mode ? {8'h00, res[7:0]} : res;
    alu_out   = pass_a ? a : res_m;
    alu_flags = {c_f, v_f, msb_of(res_m, byte_mode), res_m == 16'h0000};
  end

  always_comb begin
    flags_next = flags_reg;
    if (flags_we) begin
      case (operator_group)
        G_SFLAG: flags_next = flags_reg | decoder_flags;
        G_UFLAG: flags_next = flags_reg & ~decoder_flags;
        G_CRVMATH, G_WRRMATH, G_WRSMATH, G_CRRMATH, G_CRSMATH: flags_next[3:0] = alu_flags;
        default: ;
      endcase
    end
    // Interrupt-enable control lands on top of any flag write; clear has priority.
    if (int_en_clr) begin
      flags_next[4] = 1'b0;
    end else if (int_en_set) begin
      flags_next[4] = 1'b1;
    end
  end

  assign flags = flags_reg;

  always_comb begin
    case (operator)
      4'd0:    is_checked = 1'b0;
      4'd1:    is_checked = flags_reg[0];
      4'd2:    is_checked = !flags_reg[0];
      4'd3:    is_checked = flags_reg[3];
      4'd4:    is_checked = !flags_reg[3];
      4'd5:    is_checked = flags_reg[1];
      4'd6:    is_checked = !flags_reg[1];
      4'd7:    is_checked = flags_reg[2];
      4'd8:    is_checked = !flags_reg[2];
      4'd9:    is_checked = flags_reg[1] == flags_reg[2];
      4'd10:   is_checked = flags_reg[1] != flags_reg[2];
      4'd11:   is_checked = !flags_reg[3] && !flags_reg[0];
      4'd12:   is_checked = flags_reg[3] || flags_reg[0];
      4'd13:   is_checked = !flags_reg[0] && (flags_reg[1] == flags_reg[2]);
      4'd14:   is_checked = flags_reg[0] || (flags_reg[1] != flags_reg[2]);
      default: is_checked = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_decode_alu_branch.sv
// Self-checking bench for decode_alu_branch: directed cases plus randomized decode/ALU/flag runs
// compared against an integer-arithmetic reference model.
`timescale 1ns/1ps
module tb_decode_alu_branch;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] word_in;
  logic        word_load;
  logic [15:0] value1;
  logic [15:0] value2;
  logic        flags_we;
  logic        int_en_clr;
  logic        int_en_set;
  logic [3:0]  operator_group;
  logic [3:0]  operator;
  logic [2:0]  rg1;
  logic [2:0]  rg2;
  logic [7:0]  val;
  logic [7:0]  decoder_flags;
  logic [9:0]  relative_addr;
  logic [15:0] alu_out;
  logic [3:0]  alu_flags;
  logic [7:0]  flags;
  logic        is_checked;

  int checks = 0;
  int errors = 0;
  logic [15:0] mword;
  logic [7:0]  mflags;

  typedef struct packed {
    logic [3:0] grp;
    logic [3:0] op;
    logic [2:0] r1;
    logic [2:0] r2;
    logic [7:0] v;
    logic [7:0] df;
    logic [9:0] rel;
  } dec_t;

  decode_alu_branch dut (
    .clk(clk), .reset(reset), .word_in(word_in), .word_load(word_load),
    .value1(value1), .value2(value2), .flags_we(flags_we),
    .int_en_clr(int_en_clr), .int_en_set(int_en_set),
    .operator_group(operator_group), .operator(operator), .rg1(rg1), .rg2(rg2),
    .val(val), .decoder_flags(decoder_flags), .relative_addr(relative_addr),
    .alu_out(alu_out), .alu_flags(alu_flags), .flags(flags), .is_checked(is_checked)
  );

  always #5 clk = ~clk;

  function automatic dec_t ref_decode(input logic [15:0] w);
    dec_t d;
    d = '0;
    if (w[15:14] == 2'b00) begin
      d.grp = 4'd0; d.op = w[13:10]; d.rel = w[9:0];
    end else if (w[15:14] == 2'b01) begin
      d.grp = 4'd1; d.op = {1'b0, w[13:11]}; d.r1 = w[10:8]; d.v = w[7:0];
    end else if (w[15:12] != 4'hF) begin
      d.grp = w[15:12]; d.r1 = w[11:9]; d.r2 = w[8:6]; d.op = w[3:0];
    end else begin
      d.grp = (w[11:10] == 2'd0) ? 4'd4 : (w[11:10] == 2'd1) ? 4'd2 :
              (w[11:10] == 2'd2) ? 4'd3 : 4'd5;
      d.df = w[7:0]; d.op = w[3:0];
    end
    return d;
  endfunction

  function automatic int sg(input int x, input int w);
    return (x >= (1 << (w - 1))) ? x - (1 << w) : x;
  endfunction

  function automatic logic ovf(input int s, input int w);
    return (s > (1 << (w - 1)) - 1) || (s < -(1 << (w - 1)));
  endfunction

  function automatic void ref_alu(input logic [3:0] g, input logic [3:0] op,
                                  input logic [15:0] v1, input logic [15:0] v2,
                                  input logic [7:0] fl,
                                  output logic [15:0] out, output logic [3:0] af);
    int w, m, h, x, y, cin, res, full, k;
    logic c, v, is_byte, single, cmp;
    is_byte = (g == 4'd1) || (g == 4'd10) || (g == 4'd11);
    single  = (g == 4'd9) || (g == 4'd11);
    w = is_byte ? 8 : 16;
    m = (1 << w) - 1;
    h = 1 << (w - 1);
    x = int'(v1) & m;
    y = int'(v2) & m;
    cin = fl[3] ? 1 : 0;
    c = fl[3]; v = fl[2]; res = x; cmp = 1'b0;
    if (single) begin
      case (op)
        4'd0: begin full = x + 1; res = full & m; c = full > m; v = ovf(sg(x, w) + 1, w); end
        4'd1: begin full = x - 1; res = full & m; c = full < 0; v = ovf(sg(x, w) - 1, w); end
        4'd2: begin res = m - x; v = 1'b0; end
        4'd3: begin full = -x; res = full & m; c = x != 0; v = ovf(-sg(x, w), w); end
        4'd4: begin full = 2 * x; res = full & m; c = full > m; v = 1'b0; end
        4'd5: begin res = x / 2; c = (x % 2) == 1; v = 1'b0; end
        4'd6: begin res = (2 * x + cin) & m; c = x >= h; v = 1'b0; end
        4'd7: begin res = x / 2 + cin * h; c = (x % 2) == 1; v = 1'b0; end
        4'd8: begin res = is_byte ? x : (x % 256) * 256 + x / 256; v = 1'b0; end
        default: ;
      endcase
    end else begin
      case (op)
        4'd0, 4'd1: begin
          k = (op == 4'd1) ? cin : 0;
          full = x + y + k; res = full & m; c = full > m;
          v = ovf(sg(x, w) + sg(y, w) + k, w);
        end
        4'd2, 4'd3, 4'd7: begin
          k = (op == 4'd3) ? cin : 0;
          full = x - y - k; res = full & m; c = full < 0;
          v = ovf(sg(x, w) - sg(y, w) - k, w);
          cmp = (op == 4'd7);
        end
        4'd4: begin res = x & y; v = 1'b0; end
        4'd5: begin res = x | y; v = 1'b0; end
        4'd6: begin res = x ^ y; v = 1'b0; end
        4'd8: begin res = y; v = 1'b0; end
`ifdef ALU_MUL_EN
        4'd9: begin
          longint p;
          p = longint'(x) * longint'(y);
          res = int'(p & longint'(m)); c = (p >> w) != 0; v = 1'b0;
        end
`endif
        default: ;
      endcase
    end
    out = 16'(cmp ? x : res);
    af  = {c, v, res >= h, res == 0};
  endfunction

  function automatic logic ref_cond(input logic [3:0] op, input logic [7:0] fl);
    logic z, n, v, c;
    z = fl[0]; n = fl[1]; v = fl[2]; c = fl[3];
    case (op)
      4'd0:  return 1'b0;
      4'd1:  return z;
      4'd2:  return !z;
      4'd3:  return c;
      4'd4:  return !c;
      4'd5:  return n;
      4'd6:  return !n;
      4'd7:  return v;
      4'd8:  return !v;
      4'd9:  return n == v;
      4'd10: return n != v;
      4'd11: return !c && !z;
      4'd12: return c || z;
      4'd13: return !z && (n == v);
      4'd14: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [7:0] ref_flags(input logic [15:0] w, input logic [15:0] v1,
                                           input logic [15:0] v2, input logic [7:0] fl,
                                           input logic clr, input logic set);
    dec_t d;
    logic [15:0] o;
    logic [3:0] af;
    logic [7:0] nf;
    d = ref_decode(w);
    nf = fl;
    if (d.grp == 4'd2) nf = fl | d.df;
    else if (d.grp == 4'd3) nf = fl & ~d.df;
    else if (d.grp inside {4'd1, 4'd8, 4'd9, 4'd10, 4'd11}) begin
      ref_alu(d.grp, d.op, v1, v2, fl, o, af);
      nf[3:0] = af;
    end
    if (clr) nf[4] = 1'b0;
    else if (set) nf[4] = 1'b1;
    return nf;
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0080;
      5: return 16'h007F;
      6: return 16'h0001;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic load_word(input logic [15:0] w);
    word_in = w;
    word_load = 1'b1;
    @(posedge clk);
    #1;
    word_load = 1'b0;
    mword = w;
  endtask

  task automatic commit(input logic clr, input logic set);
    logic [7:0] nf;
    nf = ref_flags(mword, value1, value2, mflags, clr, set);
    flags_we = 1'b1; int_en_clr = clr; int_en_set = set;
    @(posedge clk);
    #1;
    flags_we = 1'b0; int_en_clr = 1'b0; int_en_set = 1'b0;
    mflags = nf;
  endtask

  task automatic set_flags(input logic [7:0] f);
    load_word(16'hF8FF);
    commit(1'b0, 1'b0);
    load_word({8'hF4, f});
    commit(1'b0, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    mword = 16'h0000; mflags = 8'h00;
    #1;
    checks++;
    if (flags !== 8'h00) begin errors++; $display("FAIL reset_flags: got %h expected 00", flags); end
    checks++;
    if (operator_group !== 4'd0) begin errors++; $display("FAIL reset_group: got %0d expected 0", operator_group); end
    checks++;
    if (is_checked !== 1'b0) begin errors++; $display("FAIL reset_is_checked: got %b expected 0", is_checked); end
    checks++;
    if ({operator, rg1, rg2, val, decoder_flags, relative_addr} !== 36'd0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", {operator, rg1, rg2, val, decoder_flags, relative_addr});
    end
    $display("reset: flags=%h group=%0d is_checked=%b", flags, operator_group, is_checked);
    load_word(16'hC01B);
    checks++;
    if ({operator_group, operator} !== {4'd12, 4'd11}) begin
      errors++; $display("FAIL calli_decode: got group %0d op %0d expected group 12 op 11", operator_group, operator);
    end
    $display("load C01B: group=%0d op=%0d", operator_group, operator);
  endtask

  task automatic test_directed;
    set_flags(8'h00);
    load_word(16'h8000);
    value1 = 16'hFFFF; value2 = 16'h0001; #1;
    checks++;
    if (alu_out !== 16'h0000) begin errors++; $display("FAIL add_wrap_out: got %h expected 0000", alu_out); end
    commit(1'b0, 1'b0);
    checks++;
    if (flags[3:0] !== 4'b1001) begin errors++; $display("FAIL add_wrap_flags: got %b expected 1001", flags[3:0]); end
    $display("ADD FFFF+1: out=%h flags=%h", alu_out, flags);

    value1 = 16'h7FFF; value2 = 16'h0001; #1;
    checks++;
    if ({alu_out, alu_flags} !== {16'h8000, 4'b0110}) begin
      errors++; $display("FAIL add_ovf: got %h/%b expected 8000/0110", alu_out, alu_flags);
    end
    $display("ADD 7FFF+1: out=%h alu_flags=%b", alu_out, alu_flags);

    load_word(16'h5000);
    value1 = 16'h0010; value2 = 16'h0020; #1;
    checks++;
    if ({alu_out, alu_flags} !== {16'h00F0, 4'b1010}) begin
      errors++; $display("FAIL crv_sub: got %h/%b expected 00F0/1010", alu_out, alu_flags);
    end
    $display("CRVMATH SUB 10-20: out=%h alu_flags=%b", alu_out, alu_flags);

    set_flags(8'h08);
    load_word(16'h9007);
    value1 = 16'h0001; #1;
    checks++;
    if ({alu_out, alu_flags} !== {16'h8000, 4'b1010}) begin
      errors++; $display("FAIL ror_c: got %h/%b expected 8000/1010", alu_out, alu_flags);
    end
    $display("ROR 0001 C=1: out=%h alu_flags=%b", alu_out, alu_flags);

    load_word(16'hF410);
    commit(1'b0, 1'b0);
    checks++;
    if (flags !== 8'h18) begin errors++; $display("FAIL sflag: got %h expected 18", flags); end
    load_word(16'hF818);
    commit(1'b0, 1'b1);
    checks++;
    if (flags !== 8'h10) begin errors++; $display("FAIL uflag_set: got %h expected 10", flags); end
    $display("SFLAG 10 / UFLAG 18 + int_en_set: flags=%h", flags);

    load_word(16'h0000);
    commit(1'b1, 1'b1);
    checks++;
    if (flags[4] !== 1'b0) begin errors++; $display("FAIL clr_wins: got %b expected 0", flags[4]); end
    $display("int_en_clr+set: flags=%h", flags);

    set_flags(8'h01);
    load_word(16'h0800);
    checks++;
    if (is_checked !== 1'b0) begin errors++; $display("FAIL cond2_z: got %b expected 0", is_checked); end
    set_flags(8'h06);
    load_word(16'h37FF);
    checks++;
    if ({is_checked, relative_addr} !== {1'b1, 10'h3FF}) begin
      errors++; $display("FAIL cond13: got %b/%h expected 1/3FF", is_checked, relative_addr);
    end
    $display("RJMP cond13: is_checked=%b rel=%h", is_checked, relative_addr);
  endtask

  task automatic test_decode_random;
    dec_t d;
    logic [15:0] w;
    for (int i = 0; i < 40; i++) begin
      w = 16'($urandom);
      load_word(w);
      d = ref_decode(w);
      checks++;
      if ({operator_group, operator, rg1, rg2, val, decoder_flags, relative_addr} !== d) begin
        errors++;
        $display("FAIL decode %h: got %h expected %h", w,
                 {operator_group, operator, rg1, rg2, val, decoder_flags, relative_addr}, d);
      end
      checks++;
      if (is_checked !== ref_cond(d.op, mflags)) begin
        errors++; $display("FAIL decode_cond %h: got %b expected %b", w, is_checked, ref_cond(d.op, mflags));
      end
      $display("decode %h: group=%0d op=%0d", w, operator_group, operator);
    end
  endtask

  task automatic test_alu_random;
    dec_t d;
    logic [3:0] g, op, exp_af;
    logic [15:0] w, exp_out;
    logic clr, set;
    for (int i = 0; i < 150; i++) begin
      if (i % 4 == 0) begin
        load_word({4'hF, ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10, 2'b00, 8'($urandom)});
        commit(1'b0, 1'b0);
      end
      case ($urandom_range(0, 4))
        0: g = 4'd1;
        1: g = 4'd8;
        2: g = 4'd9;
        3: g = 4'd10;
        default: g = 4'd11;
      endcase
      op = 4'($urandom_range(0, 15));
      w = 16'($urandom);
      if (g == 4'd1) w = {2'b01, op[2:0], w[10:0]};
      else w = {g, w[11:4], op};
      load_word(w);
      value1 = pick(); value2 = pick(); #1;
      d = ref_decode(mword);
      ref_alu(d.grp, d.op, value1, value2, mflags, exp_out, exp_af);
      checks++;
      if ({alu_out, alu_flags} !== {exp_out, exp_af}) begin
        errors++;
        $display("FAIL alu g%0d op%0d a=%h b=%h f=%h: got %h/%b expected %h/%b",
                 d.grp, d.op, value1, value2, mflags, alu_out, alu_flags, exp_out, exp_af);
      end
      clr = ($urandom_range(0, 3) == 0);
      set = ($urandom_range(0, 1) == 1);
      commit(clr, set);
      checks++;
      if (flags !== mflags) begin
        errors++; $display("FAIL alu_commit g%0d op%0d: got %h expected %h", d.grp, d.op, flags, mflags);
      end
      checks++;
      if (is_checked !== ref_cond(d.op, mflags)) begin
        errors++; $display("FAIL alu_cond op%0d: got %b expected %b", d.op, is_checked, ref_cond(d.op, mflags));
      end
      $display("alu g%0d op%0d a=%h b=%h -> out=%h alu_flags=%b flags=%h",
               d.grp, d.op, value1, value2, alu_out, alu_flags, flags);
    end
  endtask

  task automatic test_reset_mid;
    load_word(16'hF4FF);
    commit(1'b0, 1'b0);
    load_word(16'h8A47);
    word_in = 16'hB5C3; word_load = 1'b1; flags_we = 1'b1; int_en_set = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({flags, operator_group, operator} !== 16'h0000) begin
      errors++; $display("FAIL async_reset: got flags %h group %0d op %0d expected 0", flags, operator_group, operator);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({flags, operator_group, rg1, rg2} !== 18'd0) begin
      errors++; $display("FAIL reset_overrides: got flags %h group %0d expected 0", flags, operator_group);
    end
    word_load = 1'b0; flags_we = 1'b0; int_en_set = 1'b0;
    #1;
    reset = 1'b0;
    mword = 16'h0000; mflags = 8'h00;
    @(posedge clk);
    #1;
    checks++;
    if ({flags, operator_group, is_checked} !== 13'd0) begin
      errors++; $display("FAIL after_reset: got flags %h group %0d chk %b expected 0", flags, operator_group, is_checked);
    end
    $display("mid-op reset: flags=%h group=%0d", flags, operator_group);
  endtask

  initial begin
    reset = 1'b1; word_in = 16'h0000; word_load = 1'b0;
    value1 = 16'h0000; value2 = 16'h0000;
    flags_we = 1'b0; int_en_clr = 1'b0; int_en_set = 1'b0;
    mword = 16'h0000; mflags = 8'h00;
    test_reset;
    test_directed;
    test_decode_random;
    test_alu_random;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
